// File: rtl/j1b_io_hub.sv
// J1B I/O hub: one-hot decoded UART data/status/timer registers.
// RX/TX byte FIFOs and a free-running cycle timer with a sticky match flag.
module j1b_io_hub #(
    parameter int DATA_W   = 32,
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16,
    parameter int TIMER_W  = 32
) (
    input  logic              clk,
    input  logic              resetq,
    input  logic              io_rd,
    input  logic              io_wr,
    input  logic [15:0]       mem_addr,
    input  logic [DATA_W-1:0] dout,
    output logic [DATA_W-1:0] io_din,
    output logic [7:0]        uart_tx_data,
    output logic              uart_tx_valid,
    input  logic              uart_tx_ready,
    input  logic [7:0]        uart_rx_data,
    input  logic              uart_rx_valid,
    output logic              irq
);
    localparam int RXA = $clog2(RX_DEPTH);
    localparam int TXA = $clog2(TX_DEPTH);

    logic [15:0]        addr_q, addr_d;
    logic               rd_q, wr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [7:0]         rx_mem [RX_DEPTH];
    logic [7:0]         tx_mem [TX_DEPTH];
    logic [RXA-1:0]     rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [TXA-1:0]     tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [RXA:0]       rx_cnt_q, rx_cnt_d;
    logic [TXA:0]       tx_cnt_q, tx_cnt_d;
    logic               rx_ovf_q, rx_ovf_d;
    logic               tx_ovf_q, tx_ovf_d;
    logic               tmr_match_q, tmr_match_d;
    logic [TIMER_W-1:0] cnt_q, cnt_d, cmp_q, cmp_d;

    logic sel_uart, sel_stat, sel_tmr;
    logic rx_empty, rx_full, tx_empty, tx_full;
    logic rx_pop, rx_push, tx_pop, tx_req, tx_push;
    logic stat_wr;
    logic [7:0] rx_head;
    logic [DATA_W-1:0] status;
    logic unused;

    assign sel_uart = addr_q[12];
    assign sel_stat = addr_q[13];
    assign sel_tmr  = addr_q[14];
    assign unused   = ^{addr_q[15], addr_q[11:0], wdata_q};

    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == (RXA+1)'(RX_DEPTH));
    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == (TXA+1)'(TX_DEPTH));
    assign rx_head  = rx_empty ? 8'h00 : rx_mem[rx_rp_q];

    assign uart_tx_valid = ~tx_empty;
    assign uart_tx_data  = tx_mem[tx_rp_q];
    assign irq           = tmr_match_q;

    // A pop frees an entry in the same cycle, so a full FIFO still accepts.
    assign rx_pop  = rd_q & sel_uart & ~rx_empty;
    assign rx_push = uart_rx_valid & (~rx_full | rx_pop);
    assign tx_pop  = uart_tx_valid & uart_tx_ready;
    assign tx_req  = wr_q & sel_uart;
    assign tx_push = tx_req & (~tx_full | tx_pop);
    assign stat_wr = wr_q & sel_stat;

    always_comb begin
        status        = '0;
        status[0]     = ~tx_full;
        status[1]     = ~rx_empty;
        status[2]     = rx_ovf_q;
        status[3]     = tmr_match_q;
        status[4]     = tx_ovf_q;
        status[15:8]  = 8'(rx_cnt_q);
        status[23:16] = 8'(tx_cnt_q);
    end

    always_comb begin
        io_din = '0;
        if (sel_uart) io_din = io_din | DATA_W'(rx_head);
        if (sel_stat) io_din = io_din | status;
        if (sel_tmr)  io_din = io_din | DATA_W'(cnt_q);
    end

    always_comb begin
        addr_d   = addr_q;
        rx_wp_d  = rx_wp_q;
        rx_rp_d  = rx_rp_q;
        rx_cnt_d = rx_cnt_q;
        tx_wp_d  = tx_wp_q;
        tx_rp_d  = tx_rp_q;
        tx_cnt_d = tx_cnt_q;
        if (io_rd | io_wr) addr_d = mem_addr;
        if (rx_push) rx_wp_d = rx_wp_q + 1'b1;
        if (rx_pop)  rx_rp_d = rx_rp_q + 1'b1;
        if (rx_push & ~rx_pop) rx_cnt_d = rx_cnt_q + 1'b1;
        if (rx_pop & ~rx_push) rx_cnt_d = rx_cnt_q - 1'b1;
        if (tx_push) tx_wp_d = tx_wp_q + 1'b1;
        if (tx_pop)  tx_rp_d = tx_rp_q + 1'b1;
        if (tx_push & ~tx_pop) tx_cnt_d = tx_cnt_q + 1'b1;
        if (tx_pop & ~tx_push) tx_cnt_d = tx_cnt_q - 1'b1;
    end

    // Flag clears are applied first so that a same-cycle set wins.
    always_comb begin
        rx_ovf_d    = rx_ovf_q;
        tx_ovf_d    = tx_ovf_q;
        tmr_match_d = tmr_match_q;
        cmp_d       = cmp_q;
        cnt_d       = cnt_q + 1'b1;
        if (stat_wr & wdata_q[2]) rx_ovf_d = 1'b0;
        if (stat_wr & wdata_q[4]) tx_ovf_d = 1'b0;
        if (stat_wr & wdata_q[3]) tmr_match_d = 1'b0;
        if (wr_q & sel_tmr) begin
            cmp_d       = wdata_q[TIMER_W-1:0];
            tmr_match_d = 1'b0;
        end
        if (uart_rx_valid & rx_full & ~rx_pop) rx_ovf_d = 1'b1;
        if (tx_req & tx_full & ~tx_pop) tx_ovf_d = 1'b1;
        if (cnt_q == cmp_q) tmr_match_d = 1'b1;
    end

    always_ff @(posedge clk or posedge resetq) begin
        if (resetq) begin
            addr_q      <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            rx_wp_q     <= '0;
            rx_rp_q     <= '0;
            rx_cnt_q    <= '0;
            tx_wp_q     <= '0;
            tx_rp_q     <= '0;
            tx_cnt_q    <= '0;
            rx_ovf_q    <= 1'b0;
            tx_ovf_q    <= 1'b0;
            tmr_match_q <= 1'b0;
            cnt_q       <= '0;
            cmp_q       <= '1;
        end else begin
            addr_q      <= addr_d;
            rd_q        <= io_rd;
            wr_q        <= io_wr;
            wdata_q     <= dout;
            rx_wp_q     <= rx_wp_d;
            rx_rp_q     <= rx_rp_d;
            rx_cnt_q    <= rx_cnt_d;
            tx_wp_q     <= tx_wp_d;
            tx_rp_q     <= tx_rp_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_ovf_q    <= rx_ovf_d;
            tx_ovf_q    <= tx_ovf_d;
            tmr_match_q <= tmr_match_d;
            cnt_q       <= cnt_d;
            cmp_q       <= cmp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp_q] <= uart_rx_data;
        if (tx_push) tx_mem[tx_wp_q] <= dout_byte(wdata_q);
    end

    function automatic logic [7:0] dout_byte(input logic [DATA_W-1:0] w);
        return w[7:0];
    endfunction
endmodule

// File: tb/tb_j1b_io_hub.sv
// Directed bench for j1b_io_hub: vector table plus FIFO/timer/reset sequences.
// Timer is built 8 bits wide so the wrap case fits in a short run.
module tb_j1b_io_hub;
    logic        clk = 1'b0;
    logic        resetq = 1'b1;
    logic        io_rd = 1'b0;
    logic        io_wr = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [31:0] dout = '0;
    logic [31:0] io_din;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready = 1'b0;
    logic [7:0]  uart_rx_data = '0;
    logic        uart_rx_valid = 1'b0;
    logic        irq;

    int n_pass = 0;
    int n_total = 0;
    logic [7:0] m_cnt;

    always #5 clk = ~clk;

    j1b_io_hub #(.DATA_W(32), .RX_DEPTH(16), .TX_DEPTH(16), .TIMER_W(8)) dut (
        .clk(clk), .resetq(resetq), .io_rd(io_rd), .io_wr(io_wr),
        .mem_addr(mem_addr), .dout(dout), .io_din(io_din),
        .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid),
        .uart_tx_ready(uart_tx_ready), .uart_rx_data(uart_rx_data),
        .uart_rx_valid(uart_rx_valid), .irq(irq)
    );

    // Reference cycle count: zero under reset, +1 per clock otherwise.
    always @(posedge clk or posedge resetq) begin
        if (resetq) m_cnt <= 8'h00;
        else        m_cnt <= m_cnt + 8'h01;
    end

    typedef struct {
        logic        rd;
        logic [15:0] addr;
        logic        rxv;
        logic [7:0]  rxd;
        logic        chk;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t tv[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic add(input logic rd, input logic [15:0] a, input logic rxv,
                       input logic [7:0] rxd, input logic c,
                       input logic [31:0] e, input string nm);
        vec_t v;
        v.rd = rd; v.addr = a; v.rxv = rxv; v.rxd = rxd;
        v.chk = c; v.exp = e; v.name = nm;
        tv.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        io_rd = 1'b0; io_wr = 1'b0; uart_rx_valid = 1'b0;
        resetq = 1'b1;
        tick();
        resetq = 1'b0;
    endtask

    task automatic bus_rd(input logic [15:0] a, output logic [31:0] d);
        io_rd = 1'b1; mem_addr = a;
        tick();
        io_rd = 1'b0;
        d = io_din;
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
        io_wr = 1'b1; mem_addr = a; dout = d;
        tick();
        io_wr = 1'b0;
    endtask

    task automatic rx_burst(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            uart_rx_valid = 1'b1;
            uart_rx_data  = base + 8'(i);
            tick();
        end
        uart_rx_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  c;
        logic        seen;

        // Reset state
        #2;
        chk("reset_io_din", io_din, 32'h0);
        chk("reset_tx_valid", {31'h0, uart_tx_valid}, 32'h0);
        chk("reset_irq", {31'h0, irq}, 32'h0);
        do_reset();

        // Vector table: status, RX fill/drain, multi-select OR
        add(1, 16'h2000, 0, 8'h00, 1, 32'h0000_0001, "stat_reset");
        add(0, 16'h0000, 1, 8'h41, 0, 32'h0, "rx41");
        add(0, 16'h0000, 1, 8'h42, 0, 32'h0, "rx42");
        add(0, 16'h0000, 1, 8'h43, 0, 32'h0, "rx43");
        add(1, 16'h2000, 0, 8'h00, 1, 32'h0000_0303, "stat_rx3");
        add(1, 16'h1000, 0, 8'h00, 1, 32'h0000_0041, "rd41");
        add(1, 16'h1000, 0, 8'h00, 1, 32'h0000_0042, "rd42");
        add(1, 16'h1000, 0, 8'h00, 1, 32'h0000_0043, "rd43");
        add(1, 16'h1000, 0, 8'h00, 1, 32'h0000_0000, "rd_empty");
        add(1, 16'h2000, 0, 8'h00, 1, 32'h0000_0001, "stat_empty");
        add(0, 16'h0000, 1, 8'h55, 0, 32'h0, "rx55");
        add(1, 16'h3000, 0, 8'h00, 1, 32'h0000_0157, "multi_sel");
        add(1, 16'h2000, 0, 8'h00, 1, 32'h0000_0001, "stat_after");
        foreach (tv[i]) begin
            io_rd = tv[i].rd; mem_addr = tv[i].addr;
            uart_rx_valid = tv[i].rxv; uart_rx_data = tv[i].rxd;
            tick();
            if (tv[i].chk) chk(tv[i].name, io_din, tv[i].exp);
        end
        io_rd = 1'b0; uart_rx_valid = 1'b0;
        chk("t1_tx_valid", {31'h0, uart_tx_valid}, 32'h0);
        chk("t1_irq", {31'h0, irq}, 32'h0);

        // RX overflow, W1C, push+pop while full
        do_reset();
        rx_burst(17, 8'h10);
        bus_rd(16'h2000, d); chk("rx_ovf_stat", d, 32'h0000_1007);
        bus_wr(16'h2000, 32'h4);
        bus_rd(16'h2000, d); chk("rx_ovf_clr", d, 32'h0000_1003);
        io_rd = 1'b1; mem_addr = 16'h1000;
        tick();
        io_rd = 1'b0;
        chk("rx_head_10", io_din, 32'h10);
        uart_rx_valid = 1'b1; uart_rx_data = 8'h99;
        tick();
        uart_rx_valid = 1'b0;
        bus_rd(16'h2000, d); chk("rx_full_pushpop", d, 32'h0000_1003);
        for (int i = 0; i < 16; i++) begin
            bus_rd(16'h1000, d);
            chk($sformatf("rx_drain%0d", i), d,
                (i < 15) ? 32'h11 + 32'(i) : 32'h99);
        end
        bus_rd(16'h2000, d); chk("rx_drained", d, 32'h1);

        // TX overflow and back-to-back drain
        do_reset();
        uart_tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) bus_wr(16'h1000, 32'hA0 + 32'(i));
        bus_rd(16'h2000, d); chk("tx_full_stat", d, 32'h0010_0010);
        for (int i = 0; i < 16; i++) begin
            if (i == 0) uart_tx_ready = 1'b1;
            chk($sformatf("tx_out%0d", i), {23'h0, uart_tx_valid, uart_tx_data},
                {23'h0, 1'b1, 8'hA0 + 8'(i)});
            tick();
        end
        uart_tx_ready = 1'b0;
        chk("tx_empty_valid", {31'h0, uart_tx_valid}, 32'h0);
        bus_wr(16'h2000, 32'h10);
        bus_rd(16'h2000, d); chk("tx_ovf_clr", d, 32'h1);

        // Timer compare match, W1C, wrap match
        do_reset();
        bus_rd(16'h4000, d); chk("tmr_read", d, {24'h0, m_cnt});
        c = m_cnt + 8'd10;
        bus_wr(16'h4000, {24'h0, c});
        for (int i = 0; i < 20; i++) begin
            tick();
            if (m_cnt == c) chk("irq_before", {31'h0, irq}, 32'h0);
            if (m_cnt == c + 8'd1) chk("irq_match", {31'h0, irq}, 32'h1);
        end
        bus_rd(16'h2000, d); chk("stat_match", d, 32'h9);
        bus_wr(16'h2000, 32'h8);
        tick();
        chk("irq_clr", {31'h0, irq}, 32'h0);
        bus_wr(16'h4000, 32'hFFFF_FFFF);
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            tick();
            if (m_cnt == 8'hFF) chk("irq_pre_wrap", {31'h0, irq}, 32'h0);
            if (m_cnt == 8'h00) begin
                chk("irq_wrap", {31'h0, irq}, 32'h1);
                seen = 1'b1;
            end
        end
        chk("wrap_seen", {31'h0, seen}, 32'h1);
        bus_rd(16'h4000, d); chk("tmr_after_wrap", d, {24'h0, m_cnt});

        // Reset mid-burst with a read in flight
        do_reset();
        rx_burst(17, 8'h60);
        for (int i = 0; i < 8; i++) bus_wr(16'h1000, 32'hC0 + 32'(i));
        tick();
        io_rd = 1'b1; mem_addr = 16'h1000;
        tick();
        io_rd = 1'b0;
        resetq = 1'b1;
        #1;
        chk("rst_io_din", io_din, 32'h0);
        chk("rst_tx_valid", {31'h0, uart_tx_valid}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        tick();
        resetq = 1'b0;
        chk("post_rst_io_din", io_din, 32'h0);
        bus_rd(16'h2000, d); chk("post_rst_stat", d, 32'h1);
        bus_rd(16'h1000, d); chk("post_rst_rx", d, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
